// File: rtl/escalonador_comandos.sv
// Command scheduler: turns UART byte pairs (code, address) into sensor-controller requests and
// sends the two-byte response back. Optional EMITIR timeout enabled by macro ESC_TIMEOUT_EN.
module escalonador_comandos #(
  parameter int unsigned TIMEOUT_CICLOS = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_dado,
  input  logic        rx_pronto,
  output logic [7:0]  tx_dado,
  output logic        tx_iniciar,
  input  logic        tx_ocupado,
  output logic [15:0] comando,
  input  logic        bufferPronto,
  input  logic [15:0] info,
  output logic        bufferUsado,
  output logic        ocupado
);

  typedef enum logic [2:0] {
    StOcioso, StEsperaEnd, StEmitir, StTxCod, StTxDado, StLiberar
  } state_e;

  // Per-byte transmit handshake: wait idle, pulse, blind cycle, wait idle again.
  typedef enum logic [1:0] {TxPronto, TxPulso, TxGuarda, TxEspera} tx_fase_e;

  state_e      state_q, state_d;
  tx_fase_e    fase_q, fase_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] comando_q, comando_d;
  logic [7:0]  byte_cod_q, byte_cod_d;
  logic [7:0]  byte_dado_q, byte_dado_d;
  logic [7:0]  tx_dado_q, tx_dado_d;
  logic        tx_iniciar_q, tx_iniciar_d;
  logic        usado_q, usado_d;
  logic [7:0]  tx_byte;
  logic        code_valido;

  assign tx_byte     = (state_q == StTxCod) ? byte_cod_q : byte_dado_q;
  assign code_valido = (code_q != 4'h0) && !code_q[3];

`ifdef ESC_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS + 1) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CICLOS;
`endif

  logic unused_bits;
  assign unused_bits = ^{info[15:8], rx_dado[7:5]};

  always_comb begin
    state_d      = state_q;
    fase_d       = fase_q;
    code_d       = code_q;
    comando_d    = comando_q;
    byte_cod_d   = byte_cod_q;
    byte_dado_d  = byte_dado_q;
    tx_dado_d    = tx_dado_q;
    tx_iniciar_d = 1'b0;
    usado_d      = usado_q;
`ifdef ESC_TIMEOUT_EN
    cnt_d        = '0;
`endif
    case (state_q)
      StOcioso: begin
        if (rx_pronto) begin
          code_d  = rx_dado[3:0];
          state_d = StEsperaEnd;
        end
      end
      StEsperaEnd: begin
        if (rx_pronto) begin
          if (code_valido) begin
            comando_d = {1'b1, 6'b0, rx_dado[4:0], code_q};
            state_d   = StEmitir;
          end else begin
            byte_cod_d  = 8'hFF;
            byte_dado_d = 8'h00;
            state_d     = StTxCod;
          end
        end
      end
      StEmitir: begin
        if (bufferPronto) begin
          comando_d   = 16'h0000;
          usado_d     = 1'b1;
          byte_cod_d  = {4'h0, code_q};
          byte_dado_d = info[7:0];
          state_d     = StTxCod;
`ifdef ESC_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CICLOS - 1)) begin
          comando_d   = 16'h0000;
          byte_cod_d  = 8'hFE;
          byte_dado_d = 8'h00;
          state_d     = StTxCod;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StTxCod, StTxDado: begin
        unique case (fase_q)
          TxPronto: begin
            if (!tx_ocupado) begin
              tx_dado_d    = tx_byte;
              tx_iniciar_d = 1'b1;
              fase_d       = TxPulso;
            end
          end
          TxPulso:  fase_d = TxGuarda;
          TxGuarda: fase_d = TxEspera;
          TxEspera: begin
            if (!tx_ocupado) begin
              fase_d  = TxPronto;
              state_d = (state_q == StTxCod) ? StTxDado : StLiberar;
            end
          end
        endcase
      end
      StLiberar: begin
        // Hold the consumed flag until the controller withdraws its response.
        if (!usado_q) begin
          state_d = StOcioso;
        end else if (!bufferPronto) begin
          usado_d = 1'b0;
          state_d = StOcioso;
        end
      end
      default: state_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StOcioso;
      fase_q       <= TxPronto;
      code_q       <= 4'h0;
      comando_q    <= 16'h0000;
      byte_cod_q   <= 8'h00;
      byte_dado_q  <= 8'h00;
      tx_dado_q    <= 8'h00;
      tx_iniciar_q <= 1'b0;
      usado_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fase_q       <= fase_d;
      code_q       <= code_d;
      comando_q    <= comando_d;
      byte_cod_q   <= byte_cod_d;
      byte_dado_q  <= byte_dado_d;
      tx_dado_q    <= tx_dado_d;
      tx_iniciar_q <= tx_iniciar_d;
      usado_q      <= usado_d;
    end
  end

  assign tx_dado     = tx_dado_q;
  assign tx_iniciar  = tx_iniciar_q;
  assign comando     = comando_q;
  assign bufferUsado = usado_q;
  assign ocupado     = (state_q != StOcioso);

endmodule
